// File: rtl/sevenseg_pkg.sv
// Shared definitions for the seven-segment scan controller: register map, scan
// states and the hex-to-segment table.
package sevenseg_pkg;

  localparam logic [4:0] ADR_DATA_LO = 5'h00;
  localparam logic [4:0] ADR_DATA_HI = 5'h04;
  localparam logic [4:0] ADR_EN      = 5'h08;
  localparam logic [4:0] ADR_DP      = 5'h0C;
  localparam logic [4:0] ADR_CTRL    = 5'h10;
  localparam logic [4:0] ADR_BRIGHT  = 5'h14;

  typedef enum logic {
    GUARD = 1'b0,
    SHOW  = 1'b1
  } state_e;

  // Active-low {CA,CB,CC,CD,CE,CF,CG}
  function automatic logic [6:0] hex2seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      default: seg = 7'b0111000;
    endcase
    return seg;
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  sel);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

  function automatic logic [15:0] merge_half(input logic [15:0] old_val,
                                             input logic [15:0] new_val,
                                             input logic [1:0]  sel);
    logic [15:0] res;
    res = old_val;
    for (int b = 0; b < 2; b++) begin
      if (sel[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

  function automatic logic [15:0] digit_mask(input int n);
    logic [15:0] m;
    for (int i = 0; i < 16; i++) m[i] = (i < n);
    return m;
  endfunction

  function automatic logic [63:0] nibble_mask(input int n);
    logic [63:0] m;
    for (int i = 0; i < 16; i++) m[4*i +: 4] = (i < n) ? 4'hF : 4'h0;
    return m;
  endfunction

endpackage

// File: rtl/sevenseg_scan_wb_if.sv
// Wishbone slave bus bundle for the seven-segment scan controller.
interface sevenseg_scan_wb_if;
  logic [4:0]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/sevenseg_hex_decode.sv
// Combinational hex nibble to active-low segment pattern.
module sevenseg_hex_decode
  import sevenseg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  assign seg = hex2seg(nibble);
endmodule

// File: rtl/sevenseg_scan_wb.sv
// Multiplexed seven-segment scan controller with a Wishbone register file.
// Optional brightness PWM is enabled by defining SEVENSEG_PWM_EN.
//
//   state | meaning
//   GUARD | all anodes off, ghosting guard at the start of a slot
//   SHOW  | current digit driven from its shadow registers
module sevenseg_scan_wb
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int CLK_FREQ_HZ  = 50_000_000,
  parameter int SCAN_HZ      = 8_000,
  parameter int GUARD_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  sevenseg_scan_wb_if.slave     bus,
  output logic [NUM_DIGITS-1:0] o_an,
  output logic [6:0]            o_seg,
  output logic                  o_dp
);

  localparam int SLOT = CLK_FREQ_HZ / SCAN_HZ;
  localparam int CW   = $clog2(SLOT);
  localparam logic [CW-1:0] GUARD_END = CW'(GUARD_CYCLES - 1);
  localparam logic [CW-1:0] SLOT_END  = CW'(SLOT - 1);
  localparam logic [3:0]    LAST_IDX  = 4'(NUM_DIGITS - 1);
  localparam logic [15:0]   DIG_MASK  = digit_mask(NUM_DIGITS);
  localparam logic [63:0]   NIB_MASK  = nibble_mask(NUM_DIGITS);

  logic [63:0] data_q;
  logic [15:0] en_q;
  logic [15:0] dp_q;
  logic        blank_q;
  logic        blank_d;
`ifdef SEVENSEG_PWM_EN
  logic [3:0]  bright_q;
`endif

  logic        ack_q;
  logic [31:0] dat_q;
  logic        req;
  logic        wr_en;
  logic [4:0]  reg_adr;
  logic [31:0] rd_data;
  logic        unused_adr_bits;

  state_e        state_q;
  state_e        state_d;
  logic [CW-1:0] count_q;
  logic [3:0]    idx_q;
  logic [3:0]    sh_nib;
  logic          sh_en;
  logic          sh_dp;
  logic [6:0]    seg_dec;
  logic          pwm_on;

  logic [NUM_DIGITS-1:0] an_d;
  logic [6:0]            seg_d;
  logic                  dp_d;

  // Bus: one fixed wait state, writes land on the ack cycle
  assign req             = bus.wb_cyc_i & bus.wb_stb_i & ~ack_q;
  assign wr_en           = ack_q & bus.wb_cyc_i & bus.wb_stb_i & bus.wb_we_i;
  assign reg_adr         = {bus.wb_adr_i[4:2], 2'b00};
  assign unused_adr_bits = &{1'b0, bus.wb_adr_i[1:0]};
  assign bus.wb_ack_o    = ack_q;
  assign bus.wb_dat_o    = dat_q;

  always_comb begin
    rd_data = '0;
    case (reg_adr)
      ADR_DATA_LO: rd_data = data_q[31:0];
      ADR_DATA_HI: rd_data = data_q[63:32];
      ADR_EN:      rd_data = {16'h0, en_q};
      ADR_DP:      rd_data = {16'h0, dp_q};
      ADR_CTRL:    rd_data = {31'h0, blank_q};
`ifdef SEVENSEG_PWM_EN
      ADR_BRIGHT:  rd_data = {28'h0, bright_q};
`endif
      default:     rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= req;
      dat_q <= req ? rd_data : '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_q <= '0;
      en_q   <= DIG_MASK;
      dp_q   <= '0;
    end else if (wr_en) begin
      case (reg_adr)
        ADR_DATA_LO: data_q[31:0]  <= merge_bytes(data_q[31:0], bus.wb_dat_i,
                                                  bus.wb_sel_i) & NIB_MASK[31:0];
        ADR_DATA_HI: data_q[63:32] <= merge_bytes(data_q[63:32], bus.wb_dat_i,
                                                  bus.wb_sel_i) & NIB_MASK[63:32];
        ADR_EN:      en_q <= merge_half(en_q, bus.wb_dat_i[15:0],
                                        bus.wb_sel_i[1:0]) & DIG_MASK;
        ADR_DP:      dp_q <= merge_half(dp_q, bus.wb_dat_i[15:0],
                                        bus.wb_sel_i[1:0]) & DIG_MASK;
        default: ;
      endcase
    end
  end

  // The incoming BLANK_ALL value feeds the output stage directly so the
  // anodes go dark on the cycle right after the write lands.
  always_comb begin
    blank_d = blank_q;
    if (wr_en && reg_adr == ADR_CTRL && bus.wb_sel_i[0]) blank_d = bus.wb_dat_i[0];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) blank_q <= 1'b0;
    else       blank_q <= blank_d;
  end

`ifdef SEVENSEG_PWM_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      bright_q <= 4'hF;
    else if (wr_en && reg_adr == ADR_BRIGHT && bus.wb_sel_i[0])
      bright_q <= bus.wb_dat_i[3:0];
  end

  logic [31:0] pwm_pos;
  logic [31:0] pwm_lim;
  always_comb begin
    pwm_pos = 32'(count_q) - 32'(GUARD_CYCLES);
    pwm_lim = (32'(SLOT - GUARD_CYCLES) * (32'(bright_q) + 32'd1)) >> 4;
    pwm_on  = pwm_pos < pwm_lim;
  end
`else
  assign pwm_on = 1'b1;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                 count_q <= '0;
    else if (count_q == SLOT_END) count_q <= '0;
    else                       count_q <= count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= GUARD;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      GUARD:   if (count_q == GUARD_END) state_d = SHOW;
      SHOW:    if (count_q == SLOT_END)  state_d = GUARD;
      default: state_d = GUARD;
    endcase
  end

  // Shadow capture isolates the visible slot from register writes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idx_q  <= '0;
      sh_nib <= '0;
      sh_en  <= 1'b0;
      sh_dp  <= 1'b0;
    end else begin
      if (state_q == GUARD && count_q == GUARD_END) begin
        sh_nib <= data_q[{idx_q, 2'b00} +: 4];
        sh_en  <= en_q[idx_q];
        sh_dp  <= dp_q[idx_q];
      end
      if (state_q == SHOW && count_q == SLOT_END)
        idx_q <= (idx_q == LAST_IDX) ? 4'd0 : idx_q + 4'd1;
    end
  end

  sevenseg_hex_decode u_hex_decode (
    .nibble (sh_nib),
    .seg    (seg_dec)
  );

  always_comb begin
    an_d  = '1;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (state_q == SHOW) begin
      seg_d = seg_dec;
      dp_d  = ~sh_dp;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (idx_q == 4'(i) && sh_en && !blank_d && pwm_on) an_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_an  <= '1;
      o_seg <= 7'h7F;
      o_dp  <= 1'b1;
    end else begin
      o_an  <= an_d;
      o_seg <= seg_d;
      o_dp  <= dp_d;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_wb.sv
// Self-checking bench for sevenseg_scan_wb: slot scoreboard plus bus checks.
module tb_sevenseg_scan_wb;

  localparam int ND   = 8;
  localparam int SLOT = 10;

  localparam logic [4:0] A_LO = 5'h00, A_HI = 5'h04, A_EN = 5'h08, A_DP = 5'h0C;
  localparam logic [4:0] A_CTRL = 5'h10, A_BRIGHT = 5'h14, A_HOLE = 5'h1C, A_HOLE2 = 5'h18;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [ND-1:0] o_an;
  logic [6:0]    o_seg;
  logic          o_dp;

  sevenseg_scan_wb_if bus ();

  sevenseg_scan_wb #(
    .NUM_DIGITS   (ND),
    .CLK_FREQ_HZ  (1_000_000),
    .SCAN_HZ      (100_000),
    .GUARD_CYCLES (2)
  ) dut (
    .clk   (clk),
    .rstn  (rstn),
    .bus   (bus),
    .o_an  (o_an),
    .o_seg (o_seg),
    .o_dp  (o_dp)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int edge_cnt = 0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) edge_cnt = 0;
    else       edge_cnt = edge_cnt + 1;
  end

  logic [6:0] seg_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                               7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  logic [31:0] m_lo, m_hi;
  logic [15:0] m_en, m_dp;
  logic        m_blank;
  logic [3:0]  m_bright;

  typedef struct {
    int         slot;
    logic [7:0] an;
    int         low;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t q[$];

  task automatic model_reset();
    m_lo = '0; m_hi = '0; m_en = 16'h00FF; m_dp = '0; m_blank = 1'b0;
`ifdef SEVENSEG_PWM_EN
    m_bright = 4'hF;
`else
    m_bright = 4'h0;
`endif
  endtask

  function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] w,
                                      input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = w[8*b +: 8];
    return r;
  endfunction

  function automatic exp_t exp_for(input int s);
    exp_t e;
    int d, lim;
    logic [3:0] nib;
    d = s % ND;
    nib = m_lo[d*4 +: 4];
`ifdef SEVENSEG_PWM_EN
    lim = (8 * (int'(m_bright) + 1)) >> 4;
`else
    lim = 8;
`endif
    e.slot = s;
    e.seg  = seg_tab[nib];
    e.dp   = ~m_dp[d];
    e.an   = 8'hFF;
    e.low  = 0;
    if (m_en[d] && !m_blank && lim > 0) begin
      e.an[d] = 1'b0;
      e.low   = lim;
    end
    return e;
  endfunction

  // Slot monitor: slot s, phase p for the outputs following edge number edge_cnt
  int         mon_s, mon_p, mon_low;
  logic [7:0] mon_and;
  logic [6:0] mon_seg;
  logic       mon_dp, mon_gbad, mon_sbad;
  exp_t       mon_e;

  always @(negedge clk) begin
    if (rstn && edge_cnt > 0) begin
      mon_s = (edge_cnt - 1) / SLOT;
      mon_p = (edge_cnt - 1) % SLOT;
      if (mon_p == 0) begin
        mon_and = 8'hFF; mon_low = 0; mon_gbad = 1'b0; mon_sbad = 1'b0;
      end
      if (mon_p < 2) begin
        if (o_an !== 8'hFF) mon_gbad = 1'b1;
      end else begin
        if (mon_p == 2) begin
          mon_seg = o_seg; mon_dp = o_dp;
        end else if (o_seg !== mon_seg || o_dp !== mon_dp) begin
          mon_sbad = 1'b1;
        end
        mon_and = mon_and & o_an;
        if (o_an !== 8'hFF) mon_low++;
      end
      if (mon_p == SLOT - 1) begin
        while (q.size() > 0 && q[0].slot < mon_s) begin
          checks++; errors++;
          $display("FAIL slot_missed: slot %0d never observed, now at %0d", q[0].slot, mon_s);
          void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].slot == mon_s) begin
          mon_e = q.pop_front();
          checks++;
          if (mon_and !== mon_e.an) begin
            errors++;
            $display("FAIL slot%0d_an: got %h want %h", mon_s, mon_and, mon_e.an);
          end
          checks++;
          if (mon_low !== mon_e.low) begin
            errors++;
            $display("FAIL slot%0d_low_cycles: got %0d want %0d", mon_s, mon_low, mon_e.low);
          end
          checks++;
          if (mon_seg !== mon_e.seg) begin
            errors++;
            $display("FAIL slot%0d_seg: got %b want %b", mon_s, mon_seg, mon_e.seg);
          end
          checks++;
          if (mon_dp !== mon_e.dp) begin
            errors++;
            $display("FAIL slot%0d_dp: got %b want %b", mon_s, mon_dp, mon_e.dp);
          end
          checks++;
          if (mon_gbad !== 1'b0) begin
            errors++;
            $display("FAIL slot%0d_guard: anodes active in guard, got 1 want 0", mon_s);
          end
          checks++;
          if (mon_sbad !== 1'b0) begin
            errors++;
            $display("FAIL slot%0d_tear: seg/dp changed mid-slot, got 1 want 0", mon_s);
          end
        end
      end
    end
  end

  // Called right after a negedge; returns right after a negedge.
  task automatic wb_access(input logic [4:0] adr, input logic we, input logic [31:0] wdat,
                           input logic [3:0] sel, output logic [31:0] rdat);
    bus.wb_adr_i = adr; bus.wb_we_i = we; bus.wb_dat_i = wdat; bus.wb_sel_i = sel;
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.wb_ack_o !== 1'b1) begin
      errors++;
      $display("FAIL ack_rise adr %h: got %b want 1", adr, bus.wb_ack_o);
    end
    rdat = bus.wb_dat_o;
    @(negedge clk);
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
    checks++;
    if (bus.wb_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL ack_single adr %h: got %b want 0", adr, bus.wb_ack_o);
    end
  endtask

  task automatic write_reg(input logic [4:0] adr, input logic [31:0] d, input logic [3:0] sel);
    logic [31:0] unused_rd;
    wb_access(adr, 1'b1, d, sel, unused_rd);
    case (adr)
      A_LO:   m_lo = mrg(m_lo, d, sel);
      A_HI:   m_hi = mrg(m_hi, d, sel) & 32'h0;
      A_EN:   m_en = mrg({16'h0, m_en}, d, sel) & 32'h00FF;
      A_DP:   m_dp = mrg({16'h0, m_dp}, d, sel) & 32'h00FF;
      A_CTRL: if (sel[0]) m_blank = d[0];
`ifdef SEVENSEG_PWM_EN
      A_BRIGHT: if (sel[0]) m_bright = d[3:0];
`endif
      default: ;
    endcase
  endtask

  task automatic read_check(input logic [4:0] adr, input logic [31:0] exp_v, input string nm);
    logic [31:0] r;
    wb_access(adr, 1'b0, 32'h0, 4'hF, r);
    checks++;
    if (r !== exp_v) begin
      errors++;
      $display("FAIL read_%s: got %h want %h", nm, r, exp_v);
    end
  endtask

  // d < 0 matches any digit
  task automatic wait_slot(input int d, input int p);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (edge_cnt > 0 && (edge_cnt - 1) % SLOT == p &&
          (d < 0 || ((edge_cnt - 1) / SLOT) % ND == d)) found = 1'b1;
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL wait_slot: digit %0d phase %0d not reached, got timeout want match", d, p);
    end
  endtask

  task automatic drain(input int bound);
    for (int i = 0; i < bound && q.size() > 0; i++) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d slots unobserved, want 0", q.size());
      q.delete();
    end
  endtask

  task automatic expect_scan(input int n);
    int s;
    wait_slot(-1, 5);
    s = (edge_cnt - 1) / SLOT;
    for (int i = 1; i <= n; i++) q.push_back(exp_for(s + i));
    drain((n + 2) * SLOT);
  endtask

  task automatic test_reset();
    logic [7:0] exp_an;
    rstn = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    checks++; if (o_an !== 8'hFF) begin errors++; $display("FAIL reset_an: got %h want ff", o_an); end
    checks++; if (o_seg !== 7'h7F) begin errors++; $display("FAIL reset_seg: got %h want 7f", o_seg); end
    checks++; if (o_dp !== 1'b1) begin errors++; $display("FAIL reset_dp: got %b want 1", o_dp); end
    checks++; if (bus.wb_ack_o !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", bus.wb_ack_o); end
    checks++; if (bus.wb_dat_o !== 32'h0) begin errors++; $display("FAIL reset_dat: got %h want 0", bus.wb_dat_o); end
    for (int i = 0; i <= ND; i++) q.push_back(exp_for(i));
    rstn = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      exp_an = (k >= 3 && k <= 10) ? 8'hFE : 8'hFF;
      checks++;
      if (o_an !== exp_an) begin
        errors++;
        $display("FAIL first_slot_an cycle %0d: got %h want %h", k, o_an, exp_an);
      end
    end
    drain(100);
    read_check(A_LO, 32'h0, "data_lo_rst");
    read_check(A_EN, 32'h0000_00FF, "en_rst");
    read_check(A_DP, 32'h0, "dp_rst");
    read_check(A_CTRL, 32'h0, "ctrl_rst");
    read_check(A_BRIGHT, {28'h0, m_bright}, "bright_rst");
  endtask

  task automatic test_data_lo();
    write_reg(A_LO, 32'h0000_F810, 4'hF);
    read_check(A_LO, 32'h0000_F810, "data_lo");
    expect_scan(ND);
  endtask

  task automatic test_en_dp();
    int n;
    bit prev, done;
    write_reg(A_EN, 32'h0000_0005, 4'hF);
    write_reg(A_DP, 32'h0000_0004, 4'hF);
    expect_scan(ND + 1);
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (o_an[0] === 1'b0) done = 1'b1;
    end
    n = 0; prev = 1'b0;
    for (int i = 0; i < 200 && done; i++) begin
      @(negedge clk);
      n++;
      if (o_an[0] === 1'b0 && prev) done = 1'b0;
      prev = o_an[0];
    end
    checks++;
    if (n !== 80) begin
      errors++;
      $display("FAIL scan_period: got %0d want 80", n);
    end
  endtask

  task automatic test_sel_and_reads();
    write_reg(A_EN, 32'h0000_FFFF, 4'hF);
    read_check(A_EN, 32'h0000_00FF, "en_masked");
    write_reg(A_DP, 32'h0000_0000, 4'hF);
    write_reg(A_LO, 32'hFFFF_3C77, 4'b0010);
    read_check(A_LO, 32'h0000_3C10, "data_lo_sel");
    expect_scan(ND);
    write_reg(A_HI, 32'hFFFF_FFFF, 4'hF);
    read_check(A_HI, 32'h0, "data_hi_absent");
    read_check(A_HOLE, 32'h0, "unmapped_1c");
    read_check(A_HOLE2, 32'h0, "unmapped_18");
  endtask

  task automatic test_write_boundary();
    int s;
    wait_slot(0, SLOT - 1);
    s = (edge_cnt - 1) / SLOT + 1;
    q.push_back(exp_for(s));
    write_reg(A_LO, {24'h0, 4'hA, m_lo[3:0]}, 4'b0001);
    q.push_back(exp_for(s + ND));
    drain(120);
  endtask

  task automatic test_write_in_show();
    int s;
    wait_slot(0, 2);
    s = (edge_cnt - 1) / SLOT;
    q.push_back(exp_for(s));
    write_reg(A_LO, {24'h0, m_lo[7:4], 4'h5}, 4'b0001);
    q.push_back(exp_for(s + ND));
    drain(120);
  endtask

  task automatic test_blank();
    wait_slot(0, 3);
    checks++;
    if (o_an !== 8'hFE) begin errors++; $display("FAIL blank_pre_an: got %h want fe", o_an); end
    write_reg(A_CTRL, 32'h1, 4'hF);
    checks++;
    if (o_an !== 8'hFF) begin errors++; $display("FAIL blank_immediate_an: got %h want ff", o_an); end
    read_check(A_CTRL, 32'h1, "ctrl_set");
    expect_scan(ND);
    write_reg(A_CTRL, 32'h0, 4'hF);
    expect_scan(2);
  endtask

  task automatic test_bright();
    write_reg(A_BRIGHT, 32'h7, 4'hF);
    read_check(A_BRIGHT, {28'h0, m_bright}, "bright");
    expect_scan(ND);
    write_reg(A_BRIGHT, 32'hF, 4'hF);
  endtask

  task automatic test_async_reset();
    wait_slot(0, 4);
    checks++;
    if (o_an !== 8'hFE) begin errors++; $display("FAIL mid_slot_an: got %h want fe", o_an); end
    #2 rstn = 1'b0;
    #1;
    checks++; if (o_an !== 8'hFF) begin errors++; $display("FAIL async_rst_an: got %h want ff", o_an); end
    checks++; if (o_seg !== 7'h7F) begin errors++; $display("FAIL async_rst_seg: got %h want 7f", o_seg); end
    checks++; if (o_dp !== 1'b1) begin errors++; $display("FAIL async_rst_dp: got %b want 1", o_dp); end
    @(negedge clk);
  endtask

  initial begin
    bus.wb_adr_i = '0; bus.wb_dat_i = '0; bus.wb_sel_i = '0;
    bus.wb_we_i = 1'b0; bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
    test_reset();
    test_data_lo();
    test_en_dp();
    test_sel_and_reads();
    test_write_boundary();
    test_write_in_show();
    test_blank();
    test_bright();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
